// File: rtl/matrix_fb_scanner.sv
// matrix_fb_scanner
//
// Wishbone pipelined slave holding a double-buffered 8x8 RGB frame. Each bank has eight
// 32-bit row registers with one nibble per pixel: column c is bits [31-4c -: 4], and in that
// nibble bit0=R, bit1=G, bit2=B (bit3 unused). Bus writes land in the back bank. The front
// bank is row-multiplexed onto the LED drivers, and each row slot starts with a blanking
// interval. A write to the last row commits the frame. The banks swap only at the end of the
// row-7 slot, so a frame is never shown half old and half new.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   i_wb_cyc/stb/we     bus cycle, strobe, write enable
//   i_wb_addr           row index
//   i_wb_sel            byte enables (write only)
//   i_wb_wdata          write data
//   o_wb_ack            ack, exactly one clock after each accepted transfer
//   o_wb_stall          always 0
//   o_wb_rdata          back-bank read data, registered with the ack, held otherwise
//   o_row               one-hot row enable, bit r = row r
//   o_red/green/blue    column drives, bit c = column c
//   o_frame_start       one-clock pulse when row 0 starts right after a swap
//   o_bank              current front bank index
//
// Only WB_DATA_WIDTH=32 and REG_COUNT=8 are supported.

module matrix_fb_scanner #(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT     = 8,
    parameter int unsigned WB_ADDR_WIDTH = 3,
    parameter int unsigned WB_SEL_WIDTH  = 4,
    parameter int unsigned ROW_CYCLES    = 1000,
    parameter int unsigned BLANK_CYCLES  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic [WB_DATA_WIDTH-1:0] o_wb_rdata,
    output logic [7:0]               o_row,
    output logic [7:0]               o_red,
    output logic [7:0]               o_green,
    output logic [7:0]               o_blue,
    output logic                     o_frame_start,
    output logic                     o_bank
);

    localparam int unsigned SlotCycles = BLANK_CYCLES + ROW_CYCLES;
    localparam int unsigned PhaseW     = $clog2(SlotCycles);
    localparam int unsigned Cols       = 8;

    localparam logic [PhaseW-1:0]        PhaseLast = PhaseW'(SlotCycles - 1);
    localparam logic [PhaseW-1:0]        PhaseLit  = PhaseW'(BLANK_CYCLES);
    localparam logic [WB_ADDR_WIDTH-1:0] RowLast   = WB_ADDR_WIDTH'(REG_COUNT - 1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic accept;
    logic wr_en;
    logic rd_en;
    logic wr_last;

    assign accept  = i_wb_cyc & i_wb_stb;
    assign wr_en   = accept & i_wb_we;
    assign rd_en   = accept & ~i_wb_we;
    assign wr_last = wr_en & (i_wb_addr == RowLast);

    // ------------------------------------------------------------------
    // Frame storage: mem_q[bank][row]
    // ------------------------------------------------------------------
    logic [WB_DATA_WIDTH-1:0] mem_q [2][REG_COUNT];

    logic                     bank_q, bank_d;
    logic                     back_bank;
    logic [WB_DATA_WIDTH-1:0] back_word;
    logic [WB_DATA_WIDTH-1:0] wr_word;

    assign back_bank = ~bank_q;
    assign back_word = mem_q[back_bank][i_wb_addr];

    // Byte-lane merge so that unselected lanes keep their old contents
    always_comb begin
        wr_word = back_word;
        for (int k = 0; k < int'(WB_SEL_WIDTH); k++) begin
            if (i_wb_sel[k]) begin
                wr_word[8*k +: 8] = i_wb_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(REG_COUNT); r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[back_bank][i_wb_addr] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Bus response
    // ------------------------------------------------------------------
    logic                     ack_q;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;

    assign rdata_d = rd_en ? back_word : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= accept;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan counters and bank swap
    // ------------------------------------------------------------------
    logic [PhaseW-1:0]        phase_q, phase_d;
    logic [WB_ADDR_WIDTH-1:0] scan_row_q, scan_row_d;
    logic                     pending_q, pending_d;
    logic                     frame_start_q;
    logic                     slot_end;
    logic                     frame_end;
    logic                     swap;

    assign slot_end  = (phase_q == PhaseLast);
    assign frame_end = slot_end & (scan_row_q == RowLast);
    // A commit in the swap cycle itself still makes it into this frame
    assign swap      = frame_end & (pending_q | wr_last);

    always_comb begin
        phase_d    = phase_q + PhaseW'(1);
        scan_row_d = scan_row_q;
        if (slot_end) begin
            phase_d    = '0;
            scan_row_d = (scan_row_q == RowLast) ? '0 : scan_row_q + WB_ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        bank_d    = bank_q ^ swap;
        pending_d = pending_q | wr_last;
        if (swap) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= '0;
            scan_row_q    <= '0;
            bank_q        <= 1'b0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            scan_row_q    <= scan_row_d;
            bank_q        <= bank_d;
            pending_q     <= pending_d;
            frame_start_q <= swap;
        end
    end

    // ------------------------------------------------------------------
    // Row/column drivers, registered one clock behind the counters
    // ------------------------------------------------------------------
    logic [WB_DATA_WIDTH-1:0] front_word;
    logic [7:0]               drv_row_q, drv_row_d;
    logic [7:0]               drv_red_q, drv_red_d;
    logic [7:0]               drv_green_q, drv_green_d;
    logic [7:0]               drv_blue_q, drv_blue_d;

    assign front_word = mem_q[bank_q][scan_row_q];

    always_comb begin
        drv_row_d   = '0;
        drv_red_d   = '0;
        drv_green_d = '0;
        drv_blue_d  = '0;
        if (phase_q >= PhaseLit) begin
            drv_row_d[scan_row_q] = 1'b1;
            // Column 0 is the most significant nibble
            for (int c = 0; c < int'(Cols); c++) begin
                drv_red_d[c]   = front_word[int'(WB_DATA_WIDTH) - 4 - 4*c];
                drv_green_d[c] = front_word[int'(WB_DATA_WIDTH) - 3 - 4*c];
                drv_blue_d[c]  = front_word[int'(WB_DATA_WIDTH) - 2 - 4*c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drv_row_q   <= '0;
            drv_red_q   <= '0;
            drv_green_q <= '0;
            drv_blue_q  <= '0;
        end else begin
            drv_row_q   <= drv_row_d;
            drv_red_q   <= drv_red_d;
            drv_green_q <= drv_green_d;
            drv_blue_q  <= drv_blue_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_wb_ack      = ack_q;
    assign o_wb_stall    = 1'b0;
    assign o_wb_rdata    = rdata_q;
    assign o_row         = drv_row_q;
    assign o_red         = drv_red_q;
    assign o_green       = drv_green_q;
    assign o_blue        = drv_blue_q;
    assign o_frame_start = frame_start_q;
    assign o_bank        = bank_q;

endmodule

// File: tb/tb_matrix_fb_scanner.sv
// Directed bench for matrix_fb_scanner with ROW_CYCLES=4 and BLANK_CYCLES=2. That gives a
// 6-clock slot and a 48-clock frame. t counts clocks since reset was released. Observation
// happens at the falling edge after clock t. The drivers at that point show the counter
// state s=t-1: phase s%6 and row (s/6)%8. Swaps are seen at t = 48k.
module tb_matrix_fb_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc, stb, we;
    logic [2:0]  addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack, stall, frame_start, bank;
    logic [31:0] rdata;
    logic [7:0]  row, red, green, blue;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    bit row_chk  = 1'b0;
    int nb;

    always #5 clk = ~clk;

    matrix_fb_scanner #(
        .WB_DATA_WIDTH(32),
        .REG_COUNT    (8),
        .WB_ADDR_WIDTH(3),
        .WB_SEL_WIDTH (4),
        .ROW_CYCLES   (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_sel     (sel),
        .i_wb_wdata   (wdata),
        .o_wb_ack     (ack),
        .o_wb_stall   (stall),
        .o_wb_rdata   (rdata),
        .o_row        (row),
        .o_red        (red),
        .o_green      (green),
        .o_blue       (blue),
        .o_frame_start(frame_start),
        .o_bank       (bank)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_row(input int tt);
        int s;
        logic [7:0] r;
        r = 8'h00;
        if (tt > 0) begin
            s = tt - 1;
            if ((s % 6) >= 2) r = 8'(1 << ((s / 6) % 8));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        t++;
        if (row_chk) check("o_row_scan", 32'(row), 32'(exp_row(t)));
    endtask

    task automatic wait_until(input int target);
        while (t < target) step();
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 3'd0; sel = 4'h0; wdata = 32'h0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; sel = s; wdata = d;
        step();
        check("write_ack", 32'(ack), 32'd1);
        bus_idle();
    endtask

    task automatic wb_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'h0; wdata = 32'h0;
        step();
        check("read_ack", 32'(ack), 32'd1);
        check(tag, rdata, exp);
        bus_idle();
    endtask

    task automatic check_lit(input string tag, input logic [7:0] r, input logic [7:0] re,
                             input logic [7:0] gr, input logic [7:0] bl);
        check({tag, "_row"}, 32'(row), 32'(r));
        check({tag, "_red"}, 32'(red), 32'(re));
        check({tag, "_green"}, 32'(green), 32'(gr));
        check({tag, "_blue"}, 32'(blue), 32'(bl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        reset = 1'b1;
        repeat (3) step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_row", 32'(row), 32'd0);
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
        t = 0;
        row_chk = 1'b1;

        // 1: idle scan of an empty frame
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_fs", 32'(frame_start), 32'd0);
            check("idle_bank", 32'(bank), 32'd0);
            check("idle_cols", {8'h0, red, green, blue}, 32'd0);
            check("idle_stall", 32'(stall), 32'd0);
        end

        // 2: full frame commit, swap at t=144
        for (int r = 0; r < 8; r++) wb_write(3'(r), 4'hF, 32'h0066_6600);
        wait_until(143);
        check("f2_pre_fs", 32'(frame_start), 32'd0);
        check("f2_pre_bank", 32'(bank), 32'd0);
        step();
        check("f2_fs", 32'(frame_start), 32'd1);
        check("f2_bank", 32'(bank), 32'd1);
        step();
        check("f2_fs_pulse", 32'(frame_start), 32'd0);
        wait_until(147);
        check_lit("f2_row0", 8'h01, 8'h00, 8'h3C, 8'h3C);
        wait_until(192);
        check("f2_noswap_fs", 32'(frame_start), 32'd0);
        check("f2_noswap_bank", 32'(bank), 32'd1);

        // 3a: commit exactly in the swap cycle (edge 239->240)
        wait_until(239);
        wb_write(3'd7, 4'hF, 32'h1111_1111);
        check("f3_fs", 32'(frame_start), 32'd1);
        check("f3_bank", 32'(bank), 32'd0);
        wait_until(285);
        check_lit("f3_row7", 8'h80, 8'hFF, 8'h00, 8'h00);
        wait_until(288);
        check("f3_nopend_fs", 32'(frame_start), 32'd0);
        check("f3_nopend_bank", 32'(bank), 32'd0);
        // 3b: commit one cycle after the swap cycle -> swap at t=336
        wb_write(3'd7, 4'hF, 32'h2222_2222);
        wait_until(335);
        check("f3b_pre_bank", 32'(bank), 32'd0);
        check("f3b_pre_fs", 32'(frame_start), 32'd0);
        step();
        check("f3b_fs", 32'(frame_start), 32'd1);
        check("f3b_bank", 32'(bank), 32'd1);
        wait_until(381);
        check_lit("f3b_row7", 8'h80, 8'h00, 8'hFF, 8'h00);

        // 4: byte enables, read-back, back-to-back reads
        wb_write(3'd2, 4'b0101, 32'hFFFF_FFFF);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd2;
        step();
        check("b2b_ack0", 32'(ack), 32'd1);
        check("sel_rdata", rdata, 32'h00FF_00FF);
        addr = 3'd7;
        step();
        check("b2b_ack1", 32'(ack), 32'd1);
        check("b2b_rdata1", rdata, 32'h1111_1111);
        check("b2b_stall", 32'(stall), 32'd0);
        bus_idle();
        step();
        check("idle_ack", 32'(ack), 32'd0);
        check("rdata_hold", rdata, 32'h1111_1111);

        // 5: rows 0-6 only never swap
        for (int r = 0; r < 7; r++) wb_write(3'(r), 4'hF, 32'h4444_4444);
        nb = (t / 48 + 1) * 48;
        for (int k = 0; k < 3; k++) begin
            wait_until(nb + 48 * k);
            check("f5_fs", 32'(frame_start), 32'd0);
            check("f5_bank", 32'(bank), 32'd1);
            wait_until(nb + 48 * k + 3);
            check_lit("f5_row0", 8'h01, 8'h00, 8'h3C, 8'h3C);
        end
        wb_write(3'd7, 4'hF, 32'h4444_4444);
        nb = (t / 48 + 1) * 48;
        wait_until(nb);
        check("f5_swap_fs", 32'(frame_start), 32'd1);
        check("f5_swap_bank", 32'(bank), 32'd0);
        wait_until(nb + 3);
        check_lit("f5_new_row0", 8'h01, 8'h00, 8'h00, 8'hFF);

        // Swap to bank 1 so the reset test sees the bank return to 0
        wb_write(3'd7, 4'hF, 32'h2222_2222);
        nb = (t / 48 + 1) * 48;
        wait_until(nb);
        check("f6_pre_bank", 32'(bank), 32'd1);

        // 6: reset in the middle of a write burst while row 3 is lit
        wait_until(nb + 20);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; wdata = 32'hDEAD_BEEF; addr = 3'd0;
        step();
        check("burst_ack0", 32'(ack), 32'd1);
        addr = 3'd1;
        step();
        check("burst_ack1", 32'(ack), 32'd1);
        check("mid_row3", 32'(row), 32'h08);
        addr = 3'd2;
        reset = 1'b1;
        t = -1;
        step();
        check("rst6_ack", 32'(ack), 32'd0);
        check("rst6_row", 32'(row), 32'd0);
        check("rst6_bank", 32'(bank), 32'd0);
        check("rst6_rdata", rdata, 32'd0);
        reset = 1'b0;
        bus_idle();
        t = 0;
        wb_read(3'd0, 32'd0, "rst6_rd0");
        wb_read(3'd7, 32'd0, "rst6_rd7");
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
